// File: rtl/adc_spi_config_ctrl.sv
// Configuration sequencer for the dual ADC 3-wire SPI port: power-up wait,
// fixed init table to both chips, then single host register writes.
module adc_spi_config_ctrl #(
    parameter int CLK_DIV        = 5,
    parameter int STARTUP_CYCLES = 500000,
    parameter int RESET_WAIT     = 50000
) (
    input  logic        clkin_50,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_chip,
    input  logic [12:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        cmd_done,
    output logic        init_done,
    output logic        busy,
    output logic        ad_sclk,
    output logic        ad_sdio,
    output logic        ada_spi_cs,
    output logic        adb_spi_cs,
    output logic        ada_oe,
    output logic        adb_oe
);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_INIT,
        ST_SHIFT,
        ST_GAP,
        ST_RWAIT,
        ST_IDLE
    } state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [15:0] div_cnt, div_nx;
    logic [5:0]  half_cnt, half_nx, half_inc;
    logic [23:0] sr, sr_nx;
    logic [1:0]  idx, idx_nx;
    logic        in_init, in_init_nx;
    logic        init_done_nx, oe_nx, sclk_nx, sdio_nx;
    logic        cs_a_nx, cs_b_nx, done_nx, busy_nx;
    logic [12:0] tbl_addr;
    logic [7:0]  tbl_data;

    always_comb begin
        case (idx)
            2'd0:    begin tbl_addr = 13'h000; tbl_data = 8'h3C; end
            2'd1:    begin tbl_addr = 13'h014; tbl_data = 8'h00; end
            2'd2:    begin tbl_addr = 13'h016; tbl_data = 8'h00; end
            default: begin tbl_addr = 13'h0FF; tbl_data = 8'h01; end
        endcase
    end

    assign cmd_ready = (state == ST_IDLE) && init_done && !init_start;

    always_comb begin
        state_nx     = state;
        cnt_nx       = (&cnt) ? cnt : cnt + 32'd1;
        div_nx       = div_cnt;
        half_nx      = half_cnt;
        half_inc     = half_cnt + 6'd1;
        sr_nx        = sr;
        idx_nx       = idx;
        in_init_nx   = in_init;
        init_done_nx = init_done;
        oe_nx        = ada_oe;
        sclk_nx      = ad_sclk;
        sdio_nx      = ad_sdio;
        cs_a_nx      = ada_spi_cs;
        cs_b_nx      = adb_spi_cs;
        done_nx      = 1'b0;

        case (state)
            ST_STARTUP: begin
                if (cnt >= 32'(STARTUP_CYCLES - 1)) begin
                    state_nx   = ST_INIT;
                    cnt_nx     = '0;
                    idx_nx     = 2'd0;
                    in_init_nx = 1'b1;
                end
            end
            ST_INIT: begin
                state_nx = ST_SHIFT;
                cnt_nx   = '0;
                div_nx   = '0;
                half_nx  = '0;
                sr_nx    = {3'b000, tbl_addr, tbl_data};
                sdio_nx  = sr_nx[23];
                sclk_nx  = 1'b0;
                cs_a_nx  = 1'b0;
                cs_b_nx  = 1'b0;
            end
            ST_SHIFT: begin
                // Each half-period boundary either raises SCLK (odd) or lowers
                // it and presents the next bit (even); half 49 closes the frame.
                if (div_cnt == 16'(CLK_DIV - 1)) begin
                    div_nx  = '0;
                    half_nx = half_inc;
                    if (half_inc == 6'd49) begin
                        sclk_nx  = 1'b0;
                        sdio_nx  = 1'b0;
                        cs_a_nx  = 1'b1;
                        cs_b_nx  = 1'b1;
                        done_nx  = !in_init;
                        state_nx = ST_GAP;
                        cnt_nx   = '0;
                    end else if (half_inc[0]) begin
                        sclk_nx = 1'b1;
                    end else begin
                        sclk_nx = 1'b0;
                        if (half_inc != 6'd48) begin
                            sr_nx   = {sr[22:0], 1'b0};
                            sdio_nx = sr[22];
                        end
                    end
                end else begin
                    div_nx = div_cnt + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt >= 32'(2 * CLK_DIV - 1)) begin
                    cnt_nx = '0;
                    if (!in_init) begin
                        state_nx = ST_IDLE;
                    end else if (idx == 2'd0) begin
                        state_nx = ST_RWAIT;
                    end else if (idx != 2'd3) begin
                        state_nx = ST_INIT;
                        idx_nx   = idx + 2'd1;
                    end else begin
                        state_nx     = ST_IDLE;
                        in_init_nx   = 1'b0;
                        init_done_nx = 1'b1;
                        oe_nx        = 1'b0;
                    end
                end
            end
            ST_RWAIT: begin
                if (cnt >= 32'(RESET_WAIT - 1)) begin
                    state_nx = ST_INIT;
                    idx_nx   = 2'd1;
                    cnt_nx   = '0;
                end
            end
            ST_IDLE: begin
                if (init_start) begin
                    state_nx     = ST_INIT;
                    idx_nx       = 2'd0;
                    in_init_nx   = 1'b1;
                    init_done_nx = 1'b0;
                    oe_nx        = 1'b1;
                    cnt_nx       = '0;
                end else if (cmd_valid && init_done) begin
                    // An empty chip mask completes without touching the bus.
                    if (cmd_chip == 2'b00) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = ST_SHIFT;
                        cnt_nx   = '0;
                        div_nx   = '0;
                        half_nx  = '0;
                        sr_nx    = {3'b000, cmd_addr, cmd_data};
                        sdio_nx  = sr_nx[23];
                        sclk_nx  = 1'b0;
                        cs_a_nx  = !cmd_chip[0];
                        cs_b_nx  = !cmd_chip[1];
                    end
                end
            end
            default: state_nx = ST_STARTUP;
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clkin_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_STARTUP;
            cnt        <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            sr         <= '0;
            idx        <= 2'd0;
            in_init    <= 1'b0;
            init_done  <= 1'b0;
            ada_oe     <= 1'b1;
            adb_oe     <= 1'b1;
            ad_sclk    <= 1'b0;
            ad_sdio    <= 1'b0;
            ada_spi_cs <= 1'b1;
            adb_spi_cs <= 1'b1;
            cmd_done   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            div_cnt    <= div_nx;
            half_cnt   <= half_nx;
            sr         <= sr_nx;
            idx        <= idx_nx;
            in_init    <= in_init_nx;
            init_done  <= init_done_nx;
            ada_oe     <= oe_nx;
            adb_oe     <= oe_nx;
            ad_sclk    <= sclk_nx;
            ad_sdio    <= sdio_nx;
            ada_spi_cs <= cs_a_nx;
            adb_spi_cs <= cs_b_nx;
            cmd_done   <= done_nx;
            busy       <= busy_nx;
        end
    end

endmodule
